// File: rtl/jtvigil_scr2_ctrl.sv
// jtvigil_scr2_ctrl: rear-layer (scr2) scroll/palette/enable register block.
// The CPU writes shadow registers. Shadow values move to the active outputs
// at the start of vertical blank, so the picture never changes mid-frame.
// A registered scrolled horizontal position is produced for the tile fetcher.
//
// Build option:
//   JTVIGIL_SCR2_DBUF_EN defined   -> double-buffered updates at blank start.
//   JTVIGIL_SCR2_DBUF_EN undefined -> writes take effect on the next clock edge,
//                                     and upd_pend stays low.
module jtvigil_scr2_ctrl (
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic        LVBL,
    input  logic [8:0]  hdump,
    input  logic        io_wr,
    input  logic [1:0]  io_addr,
    input  logic [7:0]  cpu_dout,
    output logic [10:0] scrx,
    output logic [2:0]  scr_pal,
    output logic        scr_en,
    output logic [10:0] scr_hpos,
    output logic        upd_pend
);

    localparam logic [1:0] AddrXLo = 2'd0;
    localparam logic [1:0] AddrXHi = 2'd1;
    localparam logic [1:0] AddrCfg = 2'd2;

    // Shadow registers, written by the CPU
    logic [10:0] shx_q, shx_d;
    logic [2:0]  shpal_q, shpal_d;
    logic        shen_q, shen_d;

    // Active registers, seen by the video side
    logic [10:0] scrx_q, scrx_d;
    logic [2:0]  pal_q, pal_d;
    logic        en_q, en_d;

    logic        pend_q, pend_d;
    logic        lvbl_l_q;
    logic [10:0] hpos_q, hpos_d;

    logic        wr_lo, wr_hi, wr_cfg, wr_any;
    logic        blank_start;

    // Decode the CPU write strobe; address 3 selects nothing
    always_comb begin
        wr_lo  = io_wr && (io_addr == AddrXLo);
        wr_hi  = io_wr && (io_addr == AddrXHi);
        wr_cfg = io_wr && (io_addr == AddrCfg);
        wr_any = wr_lo || wr_hi || wr_cfg;
    end

    // LVBL was high on the previous edge and is low now
    assign blank_start = lvbl_l_q && !LVBL;

    // Shadow register next state; X low and high halves are written independently
    always_comb begin
        shx_d   = shx_q;
        shpal_d = shpal_q;
        shen_d  = shen_q;
        if (wr_lo) begin
            shx_d[7:0] = cpu_dout;
        end
        if (wr_hi) begin
            shx_d[10:8] = cpu_dout[2:0];
        end
        if (wr_cfg) begin
            shpal_d = cpu_dout[2:0];
            shen_d  = cpu_dout[6];
        end
    end

`ifdef JTVIGIL_SCR2_DBUF_EN
    // Blank start copies the pre-write shadow; a write in the same cycle stays pending
    always_comb begin
        scrx_d = scrx_q;
        pal_d  = pal_q;
        en_d   = en_q;
        pend_d = pend_q;
        if (blank_start) begin
            scrx_d = shx_q;
            pal_d  = shpal_q;
            en_d   = shen_q;
            pend_d = 1'b0;
        end
        if (wr_any) begin
            pend_d = 1'b1;
        end
    end
`else
    // Active tracks the shadow directly, so the blank copy would be a no-op
    always_comb begin
        scrx_d = shx_d;
        pal_d  = shpal_d;
        en_d   = shen_d;
        pend_d = 1'b0;
    end
`endif

    // Scrolled position advances only on pixel enables, using the current active X
    always_comb begin
        hpos_d = hpos_q;
        if (pxl_cen) begin
            hpos_d = {2'b00, hdump} + scrx_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            shx_q    <= 11'd0;
            shpal_q  <= 3'd0;
            shen_q   <= 1'b1;
            scrx_q   <= 11'd0;
            pal_q    <= 3'd0;
            en_q     <= 1'b1;
            pend_q   <= 1'b0;
            lvbl_l_q <= 1'b1;
            hpos_q   <= 11'd0;
        end else begin
            shx_q    <= shx_d;
            shpal_q  <= shpal_d;
            shen_q   <= shen_d;
            scrx_q   <= scrx_d;
            pal_q    <= pal_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            lvbl_l_q <= LVBL;
            hpos_q   <= hpos_d;
        end
    end

    assign scrx     = scrx_q;
    assign scr_pal  = pal_q;
    assign scr_en   = en_q;
    assign scr_hpos = hpos_q;
    assign upd_pend = pend_q;

endmodule

// File: tb/tb_jtvigil_scr2_ctrl.sv
// Directed testbench for jtvigil_scr2_ctrl; expectations follow JTVIGIL_SCR2_DBUF_EN.
module tb_jtvigil_scr2_ctrl;

    logic        rst;
    logic        clk;
    logic        pxl_cen;
    logic        LVBL;
    logic [8:0]  hdump;
    logic        io_wr;
    logic [1:0]  io_addr;
    logic [7:0]  cpu_dout;
    logic [10:0] scrx;
    logic [2:0]  scr_pal;
    logic        scr_en;
    logic [10:0] scr_hpos;
    logic        upd_pend;

    int checks = 0;
    int errors = 0;

`ifdef JTVIGIL_SCR2_DBUF_EN
    localparam bit Dbuf = 1'b1;
`else
    localparam bit Dbuf = 1'b0;
`endif

    jtvigil_scr2_ctrl dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
        .LVBL     (LVBL),
        .hdump    (hdump),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .cpu_dout (cpu_dout),
        .scrx     (scrx),
        .scr_pal  (scr_pal),
        .scr_en   (scr_en),
        .scr_hpos (scr_hpos),
        .upd_pend (upd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        io_wr    = 1'b1;
        io_addr  = a;
        cpu_dout = d;
        tick();
        io_wr    = 1'b0;
    endtask

    task automatic do_blank();
        LVBL = 1'b0;
        tick();
        LVBL = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Writes and pixel enables during reset must be ignored
        rst = 1'b1;
        io_wr = 1'b1; io_addr = 2'd0; cpu_dout = 8'h55;
        pxl_cen = 1'b1; hdump = 9'h0AA;
        tick();
        tick();
        io_wr = 1'b0; pxl_cen = 1'b0; rst = 1'b0;
        checks++; if (scrx !== 11'h000) begin errors++; $display("FAIL reset_scrx got %h want 000", scrx); end
        checks++; if (scr_pal !== 3'd0) begin errors++; $display("FAIL reset_pal got %h want 0", scr_pal); end
        checks++; if (scr_en !== 1'b1) begin errors++; $display("FAIL reset_en got %b want 1", scr_en); end
        checks++; if (scr_hpos !== 11'h000) begin errors++; $display("FAIL reset_hpos got %h want 000", scr_hpos); end
        checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b want 0", upd_pend); end
        do_blank();
        checks++; if (scrx !== 11'h000) begin errors++; $display("FAIL reset_wr_ignored got %h want 000", scrx); end
    endtask

    task automatic test_update();
        do_write(2'd0, 8'h34);
        if (Dbuf) begin
            do_write(2'd1, 8'h05);
            checks++; if (scrx !== 11'h000) begin errors++; $display("FAIL dbuf_hold got %h want 000", scrx); end
            checks++; if (upd_pend !== 1'b1) begin errors++; $display("FAIL dbuf_pend got %b want 1", upd_pend); end
            LVBL = 1'b0;
            tick();
            checks++; if (scrx !== 11'h534) begin errors++; $display("FAIL dbuf_copy got %h want 534", scrx); end
            checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL dbuf_pend_clr got %b want 0", upd_pend); end
            tick();
            // Held-low LVBL must not re-copy
            do_write(2'd0, 8'h12);
            tick();
            checks++; if (scrx !== 11'h534) begin errors++; $display("FAIL dbuf_no_retrig got %h want 534", scrx); end
            LVBL = 1'b1;
            tick();
            do_blank();
            checks++; if (scrx !== 11'h512) begin errors++; $display("FAIL x_lo_only got %h want 512", scrx); end
            do_write(2'd1, 8'h02);
            do_blank();
            checks++; if (scrx !== 11'h212) begin errors++; $display("FAIL x_hi_only got %h want 212", scrx); end
        end else begin
            checks++; if (scrx !== 11'h034) begin errors++; $display("FAIL direct_wr got %h want 034", scrx); end
            checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL direct_pend got %b want 0", upd_pend); end
            do_write(2'd0, 8'h10);
            checks++; if (scrx !== 11'h010) begin errors++; $display("FAIL direct_wr10 got %h want 010", scrx); end
            do_write(2'd1, 8'h05);
            checks++; if (scrx !== 11'h510) begin errors++; $display("FAIL x_hi_only got %h want 510", scrx); end
            do_write(2'd0, 8'h34);
            checks++; if (scrx !== 11'h534) begin errors++; $display("FAIL x_lo_only got %h want 534", scrx); end
            do_blank();
            checks++; if (scrx !== 11'h534) begin errors++; $display("FAIL direct_blank got %h want 534", scrx); end
            checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL direct_pend2 got %b want 0", upd_pend); end
        end
    endtask

    task automatic test_hpos();
        do_write(2'd0, 8'hFF);
        do_write(2'd1, 8'h07);
        if (Dbuf) do_blank();
        checks++; if (scrx !== 11'h7FF) begin errors++; $display("FAIL hpos_scrx got %h want 7FF", scrx); end
        hdump = 9'h002;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        checks++; if (scr_hpos !== 11'h001) begin errors++; $display("FAIL hpos_wrap got %h want 001", scr_hpos); end
        hdump = 9'h005;
        tick();
        tick();
        checks++; if (scr_hpos !== 11'h001) begin errors++; $display("FAIL hpos_hold got %h want 001", scr_hpos); end
        hdump = 9'h100;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        checks++; if (scr_hpos !== 11'h0FF) begin errors++; $display("FAIL hpos_sum got %h want 0FF", scr_hpos); end
        hdump = 9'h1FF;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        checks++; if (scr_hpos !== 11'h1FE) begin errors++; $display("FAIL hpos_max got %h want 1FE", scr_hpos); end
    endtask

    task automatic test_same_cycle();
        do_write(2'd2, 8'h42);
        if (Dbuf) do_blank();
        checks++; if (scr_pal !== 3'd2) begin errors++; $display("FAIL pal_setup got %h want 2", scr_pal); end
        // Write and blank start in the same cycle
        LVBL = 1'b0;
        io_wr = 1'b1; io_addr = 2'd2; cpu_dout = 8'h45;
        tick();
        io_wr = 1'b0;
        LVBL = 1'b1;
        if (Dbuf) begin
            checks++; if (scr_pal !== 3'd2) begin errors++; $display("FAIL same_pal got %h want 2", scr_pal); end
            checks++; if (upd_pend !== 1'b1) begin errors++; $display("FAIL same_pend got %b want 1", upd_pend); end
        end else begin
            checks++; if (scr_pal !== 3'd5) begin errors++; $display("FAIL same_pal got %h want 5", scr_pal); end
            checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL same_pend got %b want 0", upd_pend); end
        end
        checks++; if (scr_en !== 1'b1) begin errors++; $display("FAIL same_en got %b want 1", scr_en); end
        tick();
        do_blank();
        checks++; if (scr_pal !== 3'd5) begin errors++; $display("FAIL next_pal got %h want 5", scr_pal); end
        checks++; if (scr_en !== 1'b1) begin errors++; $display("FAIL next_en got %b want 1", scr_en); end
        checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL next_pend got %b want 0", upd_pend); end
        do_write(2'd2, 8'h03);
        if (Dbuf) do_blank();
        checks++; if (scr_pal !== 3'd3) begin errors++; $display("FAIL pal3 got %h want 3", scr_pal); end
        checks++; if (scr_en !== 1'b0) begin errors++; $display("FAIL en_off got %b want 0", scr_en); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        do_write(2'd0, 8'hFF);
        checks++; if (upd_pend !== Dbuf) begin errors++; $display("FAIL pend_before_rst got %b want %b", upd_pend, Dbuf); end
        do_reset();
        do_blank();
        checks++; if (scrx !== 11'h000) begin errors++; $display("FAIL rst_discard got %h want 000", scrx); end
        checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL rst_pend got %b want 0", upd_pend); end
    endtask

    task automatic test_addr3();
        do_reset();
        do_write(2'd3, 8'hFF);
        checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL a3_pend got %b want 0", upd_pend); end
        do_blank();
        checks++; if (scrx !== 11'h000) begin errors++; $display("FAIL a3_scrx got %h want 000", scrx); end
        checks++; if (scr_pal !== 3'd0) begin errors++; $display("FAIL a3_pal got %h want 0", scr_pal); end
        checks++; if (scr_en !== 1'b1) begin errors++; $display("FAIL a3_en got %b want 1", scr_en); end
        checks++; if (scr_hpos !== 11'h000) begin errors++; $display("FAIL a3_hpos got %h want 000", scr_hpos); end
        checks++; if (upd_pend !== 1'b0) begin errors++; $display("FAIL a3_pend2 got %b want 0", upd_pend); end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LVBL = 1'b1; hdump = 9'd0;
        io_wr = 1'b0; io_addr = 2'd0; cpu_dout = 8'd0;
        test_reset();
        test_update();
        test_hpos();
        test_same_cycle();
        test_reset_pending();
        test_addr3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
